// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    localparam int         ADDR_W_DEF   = 9;
    localparam logic [8:0] RESET_PC_DEF = 9'd0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch / resolve / stack signal bundle between the sequencer and its core.
interface pc_sequencer_if #(
    parameter int ADDR_W = pc_seq_pkg::ADDR_W_DEF
);
    import pc_seq_pkg::*;

    // Handshakes: a fetch transfers on the rising edge where fetch_req and
    // fetch_ack are both high; fetch_req/fetch_addr stay stable until then.
    // A resolution transfers on the rising edge where the sequencer is waiting
    // and resolve_valid is high. Nothing transfers on an edge with stall high.
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_plus1;
    logic              resolve_valid;
    logic              resolve_ctl;
    logic [ADDR_W-1:0] resolve_target;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_err;
    logic              stall;
    logic              halt;
    logic              halted;
    seq_state_t        dbg_state;

    modport master (
        output fetch_req, fetch_addr, instr_valid, pc_plus1, ras_top, ras_err,
               halted, dbg_state,
        input  fetch_ack, resolve_valid, resolve_ctl, resolve_target,
               ras_push, ras_pop, stall, halt
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_valid, pc_plus1, ras_top, ras_err,
               halted, dbg_state,
        output fetch_ack, resolve_valid, resolve_ctl, resolve_target,
               ras_push, ras_pop, stall, halt
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_count;
    logic              r_err;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] f_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (i_push && i_pop) begin
            if (r_count != '0) r_mem[r_ptr] <= i_data;
        end else if (i_push) begin
            r_mem[f_inc(r_ptr)] <= i_data;
            r_ptr               <= f_inc(r_ptr);
            if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
        end else if (i_pop) begin
            if (r_count == '0) begin
                r_err <= 1'b1;
            end else begin
                r_ptr   <= f_dec(r_ptr);
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_top = (r_count == '0) ? '0 : r_mem[r_ptr];
    assign o_err = r_err;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch over req/ack, wait for resolution, advance PC.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    pc_sequencer_if.master  bus
);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_fetch_req, w_fetch_req_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic              r_halt_pend, w_halt_pend_nxt;
    logic              r_halted;
    logic              w_resolve;
    logic [ADDR_W-1:0] w_pc_plus1;

    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fetch_req_nxt   = r_fetch_req;
        w_instr_valid_nxt = 1'b0;
        w_halt_pend_nxt   = r_halt_pend;
        w_resolve         = 1'b0;
        if (!bus.stall) begin
            unique case (r_state)
                BOOT: begin
                    w_state_nxt     = FETCH;
                    w_fetch_req_nxt = 1'b0;
                end
                FETCH: begin
                    if (bus.halt) w_halt_pend_nxt = 1'b1;
                    // First FETCH cycle after BOOT only raises the request.
                    if (!r_fetch_req) begin
                        w_fetch_req_nxt = 1'b1;
                    end else if (bus.fetch_ack) begin
                        w_state_nxt       = WAIT;
                        w_fetch_req_nxt   = 1'b0;
                        w_instr_valid_nxt = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.resolve_valid) begin
                        w_resolve       = 1'b1;
                        w_pc_nxt        = bus.resolve_ctl ? bus.resolve_target : w_pc_plus1;
                        w_halt_pend_nxt = 1'b0;
                        if (bus.halt || r_halt_pend) begin
                            w_state_nxt = HALT;
                        end else begin
                            w_state_nxt     = FETCH;
                            w_fetch_req_nxt = 1'b1;
                        end
                    end else if (bus.halt) begin
                        w_halt_pend_nxt = 1'b1;
                    end
                end
                HALT: begin
                    w_fetch_req_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt     = BOOT;
                    w_fetch_req_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fetch_req   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halt_pend   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_req   <= w_fetch_req_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halt_pend   <= w_halt_pend_nxt;
            r_halted      <= (w_state_nxt == HALT);
        end
    end

    assign bus.fetch_req   = r_fetch_req;
    assign bus.fetch_addr  = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc_plus1    = w_pc_plus1;
    assign bus.halted      = r_halted;
    assign bus.dbg_state   = r_state;

`ifdef PC_RAS_EN
    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_push (w_resolve & bus.ras_push),
        .i_pop  (w_resolve & bus.ras_pop),
        .i_data (w_pc_plus1),
        .o_top  (bus.ras_top),
        .o_err  (bus.ras_err)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic w_unused_ras;
    assign w_unused_ras = ^{bus.ras_push, bus.ras_pop, w_resolve};
    assign bus.ras_top  = '0;
    assign bus.ras_err  = 1'b0;
`endif

endmodule
